ff_bank: RTL and testbench

Parametrised bank of WIDTH independent, individually mode-selectable flip-flops (SR, JK, D, T) sharing one clock, with synchronous active-low reset, a global clock enable and per-channel sticky detection of the SR forbidden input. It is the generalised successor to the team's single-bit SR flip-flop. It serves as the storage primitive for control/status bit arrays in the VLSI lab designs.

---
 rtl/ff_bank.sv | 112 +++++++++++
 tb/tb_ff_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Bank of WIDTH independently mode-selectable flip-flops (SR/JK/D/T) with sticky SR-conflict flags.
// Optional saturating conflict counter is built only when FF_BANK_CONFLICT_CNT_EN is defined.
module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 conflict_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     conflict_flag,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  // Out-of-range policies fall back to hold after being reported.
  localparam int POL = (SR_POLICY == 1 || SR_POLICY == 2) ? SR_POLICY : 0;

  if (SR_POLICY < 0 || SR_POLICY > 2) begin : g_bad_policy
    $error("ff_bank: SR_POLICY=%0d is illegal, treated as 0", SR_POLICY);
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_flag;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_conflict_vec;

  function automatic logic sr_resolve(input logic cur);
    if (POL == 1)      return 1'b1;
    else if (POL == 2) return 1'b0;
    else               return cur;
  endfunction

  always_comb begin
    w_q_nxt        = r_q;
    w_conflict_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode[2*i +: 2])
        MODE_SR: begin
          case ({a[i], b[i]})
            2'b10:   w_q_nxt[i] = 1'b1;
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b11: begin
              w_q_nxt[i]        = sr_resolve(r_q[i]);
              w_conflict_vec[i] = en;
            end
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        MODE_JK: begin
          case ({a[i], b[i]})
            2'b10:   w_q_nxt[i] = 1'b1;
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b11:   w_q_nxt[i] = ~r_q[i];
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        MODE_D:  w_q_nxt[i] = a[i];
        MODE_T:  w_q_nxt[i] = a[i] ? ~r_q[i] : r_q[i];
        default: w_q_nxt[i] = r_q[i];
      endcase
    end
  end

  // State update: clear is honoured even while disabled; a fresh conflict beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= INIT;
      r_flag <= '0;
    end else begin
      if (en) r_q <= w_q_nxt;
      r_flag <= (conflict_clr ? '0 : r_flag) | w_conflict_vec;
    end
  end

  assign q             = r_q;
  assign qn            = ~r_q;
  assign conflict_flag = r_flag;

`ifdef FF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_any_conflict = |w_conflict_vec;

  always_ff @(posedge clk) begin
    if (!rst_n)               r_cnt <= '0;
    else if (conflict_clr)    r_cnt <= w_any_conflict ? CNT_W'(1) : '0;
    else if (w_any_conflict)  r_cnt <= sat_inc(r_cnt);
  end

  assign conflict_cnt = r_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: four 4-channel instances sharing stimulus (SR policies 0/1/2, narrow counter).
module tb_ff_bank;

`ifdef FF_BANK_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       clr;

  logic [3:0] q0, qn0, f0;
  logic [7:0] c0;
  logic [3:0] q1, qn1, f1;
  logic [7:0] c1;
  logic [3:0] q2, qn2, f2;
  logic [7:0] c2;
  logic [3:0] q3, qn3, f3;
  logic [1:0] c3;

  int total = 0;
  int bad   = 0;

  ff_bank #(.WIDTH(4), .INIT(4'b1010), .SR_POLICY(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .conflict_clr(clr),
    .q(q0), .qn(qn0), .conflict_flag(f0), .conflict_cnt(c0));
  ff_bank #(.WIDTH(4), .INIT(4'b1010), .SR_POLICY(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .conflict_clr(clr),
    .q(q1), .qn(qn1), .conflict_flag(f1), .conflict_cnt(c1));
  ff_bank #(.WIDTH(4), .INIT(4'b1010), .SR_POLICY(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .conflict_clr(clr),
    .q(q2), .qn(qn2), .conflict_flag(f2), .conflict_cnt(c2));
  ff_bank #(.WIDTH(4), .INIT(4'b1010), .SR_POLICY(0), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .conflict_clr(clr),
    .q(q3), .qn(qn3), .conflict_flag(f3), .conflict_cnt(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ec(input int v);
    return CNT_ON ? 8'(v) : 8'd0;
  endfunction

  initial begin
    // Reset with all inputs hostile
    rst_n = 1'b0; en = 1'b1; mode = 8'b00000000; a = 4'b1111; b = 4'b1111; clr = 1'b0;
    tick();
    chk("rst_q",    8'(q0),  8'h0A);
    chk("rst_qn",   8'(qn0), 8'h05);
    chk("rst_flag", 8'(f0),  8'h00);
    chk("rst_cnt",  c0,      8'h00);
    chk("rst_q3",   8'(q3),  8'h0A);

    // SR truth table on all four channels, three policies
    rst_n = 1'b1; a = 4'b0011; b = 4'b0101;
    tick();
    chk("sr_p0_q",    8'(q0), 8'h0A);
    chk("sr_p1_q",    8'(q1), 8'h0B);
    chk("sr_p2_q",    8'(q2), 8'h0A);
    chk("sr_flag",    8'(f0), 8'h01);
    chk("sr_cnt",     c0,     ec(1));
    chk("sr_p1_flag", 8'(f1), 8'h01);

    // Zero all channels via D mode while clearing conflict state
    mode = 8'b10101010; a = 4'b0000; b = 4'b0000; clr = 1'b1;
    tick();
    chk("zero_q",    8'(q0), 8'h00);
    chk("zero_flag", 8'(f0), 8'h00);
    chk("zero_cnt",  c0,     8'h00);

    // Mixed modes {T,D,JK,SR}, a=b=1111
    clr = 1'b0; mode = 8'b11100100; a = 4'b1111; b = 4'b1111;
    tick();
    chk("mix1_q",   8'(q0), 8'h0E);
    chk("mix1_cnt", c0,     ec(1));
    tick();
    chk("mix2_q",   8'(q0), 8'h04);
    chk("mix2_cnt", c0,     ec(2));
    tick();
    chk("mix3_q",    8'(q0), 8'h0E);
    chk("mix3_qn",   8'(qn0), 8'h01);
    chk("mix3_flag", 8'(f0), 8'h01);
    chk("mix3_cnt",  c0,     ec(3));
    chk("mix3_p1_q", 8'(q1), 8'h0F);
    chk("mix3_p2_q", 8'(q2), 8'h0E);
    chk("mix3_c3",   8'(c3), ec(3));

    // Disabled: nothing moves, no conflicts detected
    en = 1'b0; mode = 8'b00000000;
    for (int k = 0; k < 5; k++) tick();
    chk("dis_q",    8'(q0), 8'h0E);
    chk("dis_flag", 8'(f0), 8'h01);
    chk("dis_cnt",  c0,     ec(3));
    chk("dis_p2_q", 8'(q2), 8'h0E);

    // Clear honoured while disabled
    clr = 1'b1;
    tick();
    chk("disclr_flag", 8'(f0), 8'h00);
    chk("disclr_cnt",  c0,     8'h00);
    chk("disclr_q",    8'(q0), 8'h0E);

    // One conflict per cycle: narrow counter saturates
    clr = 1'b0; en = 1'b1; a = 4'b0001; b = 4'b0001;
    tick(); chk("sat1", 8'(c3), ec(1));
    tick(); chk("sat2", 8'(c3), ec(2));
    tick(); chk("sat3", 8'(c3), ec(3));
    tick(); chk("sat4", 8'(c3), ec(3));
    tick(); chk("sat5", 8'(c3), ec(3));
    tick(); chk("sat6", 8'(c3), ec(3));
    chk("sat_wide", c0,     ec(6));
    chk("sat_q3",   8'(q3), 8'h0E);

    // Clear coinciding with a new conflict
    clr = 1'b1;
    tick();
    chk("clrc_cnt3",  8'(c3), ec(1));
    chk("clrc_flag3", 8'(f3), 8'h01);
    chk("clrc_cnt0",  c0,     ec(1));

    // Mid-operation reset, then first enabled update right after release
    clr = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst2_q",    8'(q0), 8'h0A);
    chk("rst2_flag", 8'(f0), 8'h00);
    chk("rst2_cnt",  c0,     8'h00);
    rst_n = 1'b1; mode = 8'b10101010; a = 4'b0101; b = 4'b0000;
    tick();
    chk("rel_q",  8'(q0),  8'h05);
    chk("rel_qn", 8'(qn0), 8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
